// File: rtl/gate_burst_seq.sv
// gate_burst_seq
//
// Purpose:
//   Counted enable generator for a downstream clock gate (clk & gate_en).
//   On an accepted start it emits `reps` windows of `len` enabled cycles,
//   separated by `gap` disabled cycles, then pulses `done` for one cycle.
//   reps == 0 runs until `stop`. len == 0 completes immediately.
//
// Configuration macro:
//   GATE_SEQ_NEGEDGE_EN - when defined, gate_en is re-registered on the
//   falling edge of clk so that clk & gate_en cannot glitch. Windows then
//   start and end half a cycle later. busy/done/pulse_cnt are unaffected.
//
// Ports:
//   clk        in   system clock (the clock gated downstream)
//   rst        in   synchronous active-high reset
//   start      in   single-cycle request, sampled only in IDLE
//   stop       in   abort, honoured in GATE or GAP
//   len        in   enabled cycles per burst (0: no burst)
//   gap        in   disabled cycles between bursts (0: back-to-back)
//   reps       in   burst count (0: run until stop)
//   gate_en    out  enable to the clock gate
//   busy       out  high while in GATE or GAP
//   done       out  one-cycle completion/abort pulse
//   pulse_cnt  out  saturating count of gate_en-high cycles since last start

module gate_burst_seq #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned PC_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] len,
  input  logic [CNT_W-1:0] gap,
  input  logic [3:0]       reps,
  output logic             gate_en,
  output logic             busy,
  output logic             done,
  output logic [PC_W-1:0]  pulse_cnt
);

  typedef enum logic [1:0] {
    StIdle,
    StGate,
    StGap,
    StDone
  } state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_gap;
  logic [3:0]       r_reps;
  logic [3:0]       r_rep_left;
  logic             r_gate_en;
  logic             r_busy;
  logic             r_done;
  logic [PC_W-1:0]  r_pulse_cnt;

  // Outputs are registered alongside the state: each transition sets the
  // output values that belong to the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_len       <= '0;
      r_gap       <= '0;
      r_reps      <= '0;
      r_rep_left  <= '0;
      r_gate_en   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pulse_cnt <= '0;
    end else begin
      r_done <= 1'b0;

      // Count every cycle the enable is presented; the IDLE start branch
      // below may override this with a clear (gate_en is low there anyway).
      if (r_gate_en && (r_pulse_cnt != {PC_W{1'b1}})) begin
        r_pulse_cnt <= r_pulse_cnt + 1'b1;
      end

      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_pulse_cnt <= '0;
            if (len != '0) begin
              r_len      <= len;
              r_gap      <= gap;
              r_reps     <= reps;
              r_cnt      <= len - 1'b1;
              r_rep_left <= reps;
              r_state    <= StGate;
              r_gate_en  <= 1'b1;
              r_busy     <= 1'b1;
            end else begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end
          end
        end

        StGate: begin
          if (stop) begin
            r_state   <= StDone;
            r_gate_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (r_rep_left == 4'd1) begin
            // Last window of a finite run: no trailing gap.
            r_state   <= StDone;
            r_gate_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            // rep_left stays 0 forever in the run-until-stop mode.
            if (r_reps != 4'd0) begin
              r_rep_left <= r_rep_left - 1'b1;
            end
            if (r_gap == '0) begin
              r_cnt <= r_len - 1'b1;
            end else begin
              r_cnt     <= r_gap - 1'b1;
              r_state   <= StGap;
              r_gate_en <= 1'b0;
            end
          end
        end

        StGap: begin
          if (stop) begin
            r_state   <= StDone;
            r_gate_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_cnt     <= r_len - 1'b1;
            r_state   <= StGate;
            r_gate_en <= 1'b1;
          end
        end

        StDone: begin
          r_state <= StIdle;
        end

        default: begin
          r_state   <= StIdle;
          r_gate_en <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef GATE_SEQ_NEGEDGE_EN
  // Retime onto the falling edge so the enable only changes while clk is low.
  logic r_gate_neg;

  always_ff @(negedge clk) begin
    if (rst) begin
      r_gate_neg <= 1'b0;
    end else begin
      r_gate_neg <= r_gate_en;
    end
  end

  assign gate_en = r_gate_neg;
`else
  assign gate_en = r_gate_en;
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign pulse_cnt = r_pulse_cnt;

endmodule

// File: tb/tb_gate_burst_seq.sv
// Directed bench for gate_burst_seq. Cycle k is the period following rising
// edge k; stimulus driven during cycle k is sampled at edge k+1. Outputs are
// sampled 1 time unit after the falling edge inside each cycle.

module tb_gate_burst_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [7:0]  len;
  logic [7:0]  gap;
  logic [3:0]  reps;
  logic        gate_en;
  logic        busy;
  logic        done;
  logic [15:0] pulse_cnt;

  int n_pass;
  int n_total;

  gate_burst_seq #(
    .CNT_W(8),
    .PC_W (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .len      (len),
    .gap      (gap),
    .reps     (reps),
    .gate_en  (gate_en),
    .busy     (busy),
    .done     (done),
    .pulse_cnt(pulse_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef GATE_SEQ_NEGEDGE_EN
  int n_misalign;
  int n_gated;
  initial begin
    n_misalign = 0;
    n_gated    = 0;
  end
  always @(gate_en) if (clk !== 1'b0) n_misalign++;
  always @(posedge clk) if (gate_en === 1'b1) n_gated++;
`endif

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_total++;
    if ({gate_en, busy, done, pulse_cnt} !== 19'd0)
      $display("FAIL reset: got gate/busy/done/cnt=%b%b%b/%0d, want 000/0",
               gate_en, busy, done, pulse_cnt);
    else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_burst();
    logic [4:0] eg, eb, ed;
    eg = 5'b11100; eb = 5'b11100; ed = 5'b00010;
    step();
`ifdef GATE_SEQ_NEGEDGE_EN
    n_gated    = 0;
    n_misalign = 0;
`endif
    len = 8'd3; gap = 8'd2; reps = 4'd1; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      start = 1'b0;
      n_total++;
      if ({gate_en, busy, done} !== {eg[5-k], eb[5-k], ed[5-k]})
        $display("FAIL single cycle %0d: got %b%b%b, want %b%b%b", k, gate_en, busy, done,
                 eg[5-k], eb[5-k], ed[5-k]);
      else n_pass++;
      if (k == 4) begin
        n_total++;
        if (pulse_cnt !== 16'd3) $display("FAIL single pulse_cnt: got %0d, want 3", pulse_cnt);
        else n_pass++;
      end
    end
`ifdef GATE_SEQ_NEGEDGE_EN
    n_total++;
    if (n_gated !== 3) $display("FAIL negedge gated pulses: got %0d, want 3", n_gated);
    else n_pass++;
    n_total++;
    if (n_misalign !== 0)
      $display("FAIL negedge alignment: got %0d misaligned edges, want 0", n_misalign);
    else n_pass++;
`endif
  endtask

  task automatic test_repeated();
    logic [13:0] eg, eb, ed;
    eg = 14'b11000110001100; eb = 14'b11111111111100; ed = 14'b00000000000010;
    step();
    len = 8'd2; gap = 8'd3; reps = 4'd3; start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      start = 1'b0;
      // Inputs change after acceptance; the latched copies must govern.
      len = 8'd7; gap = 8'd0; reps = 4'd0;
      n_total++;
      if ({gate_en, busy, done} !== {eg[14-k], eb[14-k], ed[14-k]})
        $display("FAIL repeated cycle %0d: got %b%b%b, want %b%b%b", k, gate_en, busy, done,
                 eg[14-k], eb[14-k], ed[14-k]);
      else n_pass++;
      if (k == 13) begin
        n_total++;
        if (pulse_cnt !== 16'd6) $display("FAIL repeated pulse_cnt: got %0d, want 6", pulse_cnt);
        else n_pass++;
      end
    end
  endtask

  task automatic test_len_zero();
    logic [2:0] ed;
    ed = 3'b100;
    step();
    len = 8'd0; gap = 8'd1; reps = 4'd1; start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      start = 1'b0;
      n_total++;
      if ({gate_en, busy, done} !== {1'b0, 1'b0, ed[3-k]})
        $display("FAIL len0 cycle %0d: got %b%b%b, want 00%b", k, gate_en, busy, done, ed[3-k]);
      else n_pass++;
    end
    n_total++;
    if (pulse_cnt !== 16'd0) $display("FAIL len0 pulse_cnt: got %0d, want 0", pulse_cnt);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] eg, ed;
    eg = 10'b1111111100; ed = 10'b0000000010;
    step();
    len = 8'd4; gap = 8'd0; reps = 4'd2; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      start = 1'b0;
      n_total++;
      if ({gate_en, busy, done} !== {eg[10-k], eg[10-k], ed[10-k]})
        $display("FAIL b2b cycle %0d: got %b%b%b, want %b%b%b", k, gate_en, busy, done,
                 eg[10-k], eg[10-k], ed[10-k]);
      else n_pass++;
    end
    n_total++;
    if (pulse_cnt !== 16'd8) $display("FAIL b2b pulse_cnt: got %0d, want 8", pulse_cnt);
    else n_pass++;
  endtask

  task automatic test_infinite_stop();
    logic [11:0] eg, eb, ed;
    eg = 12'b101010101000; eb = 12'b111111111100; ed = 12'b000000000010;
    step();
    len = 8'd1; gap = 8'd1; reps = 4'd0; start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      start = 1'b0;
      stop  = 1'b0;
      n_total++;
      if ({gate_en, busy, done} !== {eg[12-k], eb[12-k], ed[12-k]})
        $display("FAIL infinite cycle %0d: got %b%b%b, want %b%b%b", k, gate_en, busy, done,
                 eg[12-k], eb[12-k], ed[12-k]);
      else n_pass++;
      if (k == 11) begin
        n_total++;
        if (pulse_cnt !== 16'd5) $display("FAIL infinite pulse_cnt: got %0d, want 5", pulse_cnt);
        else n_pass++;
      end
      if (k == 4) start = 1'b1;
      if (k == 10) stop = 1'b1;
    end
  endtask

  task automatic test_reset_mid_burst();
    step();
    len = 8'd5; gap = 8'd0; reps = 4'd1; start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      start = 1'b0;
      rst   = 1'b0;
      if (k == 3) begin
        n_total++;
        if ({gate_en, busy, done, pulse_cnt} !== 19'd0)
          $display("FAIL midrst outputs: got %b%b%b/%0d, want 000/0", gate_en, busy, done,
                   pulse_cnt);
        else n_pass++;
      end
      if (k == 5) begin
        n_total++;
        if ({gate_en, busy, pulse_cnt} !== {1'b1, 1'b1, 16'd0})
          $display("FAIL midrst restart: got gate/busy/cnt=%b%b/%0d, want 11/0", gate_en, busy,
                   pulse_cnt);
        else n_pass++;
      end
      if (k == 10) begin
        n_total++;
        if ({gate_en, done, pulse_cnt} !== {1'b0, 1'b1, 16'd5})
          $display("FAIL midrst finish: got gate/done/cnt=%b%b/%0d, want 01/5", gate_en, done,
                   pulse_cnt);
        else n_pass++;
      end
      if (k == 2) rst = 1'b1;
      if (k == 4) start = 1'b1;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    len   = '0;
    gap   = '0;
    reps  = '0;
    test_reset();
    test_single_burst();
    test_repeated();
    test_len_zero();
    test_back_to_back();
    test_infinite_stop();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
